gshare_predictor: RTL and testbench
===================================

# gshare_predictor

Parametrised gshare conditional-branch predictor for the fetch stage. The block owns the global history register (GHR) and a pattern history table (PHT) of saturating counters. It updates history speculatively at fetch and repairs it from commit-time information on a misprediction. Counters are updated at commit through a saturating read-modify-write, and a post-reset sweep initialises the whole table. Predictions go to the fetch unit; commit updates arrive on the ROB output bus.

## Interface
- IDX_W, default 8: index, GHR and PC-slice width; PHT depth is 2^IDX_W.
- CTR_W, default 2: saturating counter width, minimum 2.
- INIT_STATE, default 1<<(CTR_W-1): counter value written by the init sweep (weakly taken).

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high.
- fetchValid  in  1  fetch requests a prediction this cycle.
- fetchPC  in  IDX_W  low PC bits, word-aligned.
- ready  out  1  init sweep done; predictions and commits are accepted.
- predictValid  out  1  registered; prediction outputs are valid.
- predictTaken  out  1  MSB of the counter that was read.
- predictIndex  out  IDX_W  PHT index used; carried through the ROB.
- predictState  out  CTR_W  counter value that was read; carried through the ROB.
- predictHistory  out  IDX_W  GHR value before this prediction was shifted in.
- commitValid  in  1  a conditional branch commits.
- commitIndex  in  IDX_W  its predictIndex.
- commitState  in  CTR_W  its predictState.
- commitHistory  in  IDX_W  its predictHistory.
- commitTaken  in  1  resolved outcome.
- mispredict  in  1  qualified by commitValid; resolved outcome differs from the prediction.

## Operation
- FSM states: INIT and RUN. Reset enters INIT with sweepPtr=0 and ready=0.
- INIT: each cycle, PHT[sweepPtr] <= INIT_STATE and sweepPtr++.
  - When sweepPtr reaches 2^IDX_W-1, that entry is written and the FSM goes to RUN. ready=1 from the next cycle.
  - Fetch and commit inputs are ignored in INIT.
- Index: idx = fetchPC ^ GHR. The PHT is read combinationally.
- Fetch (RUN, fetchValid, no mispredict): on the edge,
  - predictValid=1, predictTaken=PHT[idx][CTR_W-1], predictIndex=idx, predictState=PHT[idx], predictHistory=GHR;
  - GHR <= {GHR[IDX_W-2:0], predictTaken_new}.
- Otherwise predictValid=0 next cycle, and the other predict* outputs hold their previous values.
- Commit (RUN, commitValid): PHT[commitIndex] <= sat(commitState, commitTaken).
  - Taken: +1, unless the value is all-ones.
  - Not taken: -1, unless the value is 0.
  - No wrap in either direction.
- Mispredict (commitValid & mispredict): GHR <= {commitHistory[IDX_W-2:0], commitTaken}.
  - A fetch in the same cycle is squashed: predictValid=0 and no GHR shift. The PHT update still occurs.
- Write/read collision: if commitIndex==idx in the same cycle, the fetch sees the updated counter (write-first bypass).
- Counters update only at commit. The PHT is one write port plus one asynchronous read port, with the bypass mux in front of the read.

## Timing
- Reset values: ready=0, predictValid=0, predictTaken=0, predictIndex=0, predictState=0, predictHistory=0, GHR=0, sweepPtr=0, FSM=INIT.
- Reset asserted mid-sweep or mid-RUN: immediate return to INIT, and the sweep restarts from 0.
- Init latency: ready rises 2^IDX_W cycles after reset deassert (256 for IDX_W=8).
- Prediction latency: 1 cycle, fetchValid in cycle N gives predict* in cycle N+1. Back-to-back fetches run one per cycle.
- Consecutive fetch history: the fetch in N+1 indexes with a GHR that already contains prediction N.
- Commit write: visible to a fetch read in the same cycle (bypass) and in all later cycles.
- Mispredict repair: the GHR is correct for a fetch in the cycle after the mispredict.
- There is no backpressure, so fetchValid and commitValid are accepted every RUN cycle.

## Test plan
- Init: deassert reset, then hold fetchValid=1 → ready=0 and predictValid=0 for 256 cycles. ready=1 in cycle 256, then the first fetch with fetchPC=0x00 → predictState=2'b10, predictTaken=1.
- Saturation: commit index 0x05 with commitTaken=1 and commitState=2'b11 → entry stays 2'b11. With commitTaken=0 and commitState=2'b00 → entry stays 2'b00. With commitState=2'b01 and commitTaken=1 → entry reads 2'b10.
- GHR shift: GHR=0, then fetches at fetchPC 0x10 and 0x10 on consecutive cycles, both predicted taken → predictIndex 0x10 then 0x11, predictHistory 0x00 then 0x01.
- Bypass: in the same cycle, commit index 0x3C with commitState=2'b10 and taken=0, and fetch with idx=0x3C → predictState=2'b01, predictTaken=0.
- Mispredict: fetch and mispredict together, with commitHistory=0xA5 and commitTaken=0 → predictValid=0 next cycle, GHR=0x4A. The next fetch with fetchPC=0x00 → predictIndex=0x4A.
- Reset mid-sweep: assert reset at sweep cycle 100 and release it → ready rises a full 256 cycles after the release, and every entry reads INIT_STATE.

Source files
------------

// File: rtl/gshare_predictor.sv
// gshare conditional-branch predictor: global history register, pattern
// history table of saturating counters, speculative history update at fetch,
// history repair and counter training at commit, post-reset table sweep.
module gshare_predictor #(
    parameter int unsigned      IDX_W      = 8,
    parameter int unsigned      CTR_W      = 2,
    parameter logic [CTR_W-1:0] INIT_STATE = {1'b1, {(CTR_W-1){1'b0}}}
) (
    input  logic             clk,
    input  logic             reset,

    // fetch request
    input  logic             fetchValid,
    input  logic [IDX_W-1:0] fetchPC,

    // prediction to fetch
    output logic             ready,
    output logic             predictValid,
    output logic             predictTaken,
    output logic [IDX_W-1:0] predictIndex,
    output logic [CTR_W-1:0] predictState,
    output logic [IDX_W-1:0] predictHistory,

    // commit-time update from the ROB
    input  logic             commitValid,
    input  logic [IDX_W-1:0] commitIndex,
    input  logic [CTR_W-1:0] commitState,
    input  logic [IDX_W-1:0] commitHistory,
    input  logic             commitTaken,
    input  logic             mispredict
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] sweep_q;
    logic [IDX_W-1:0] sweep_d;
    logic [IDX_W-1:0] ghr_q;

    logic [CTR_W-1:0] pht [DEPTH];

    logic             run;
    logic             squash;
    logic             fetch_fire;
    logic             repair;
    logic [IDX_W-1:0] idx;
    logic [CTR_W-1:0] sat_val;
    logic             bypass;
    logic [CTR_W-1:0] rd_state;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [CTR_W-1:0] wr_data;

    // The repaired history drops the oldest bit of the committed history.
    logic             unused_hist_msb;
    assign unused_hist_msb = commitHistory[IDX_W-1];

    // Qualifiers for this cycle's fetch and repair.
    always_comb begin
        run        = (state_q == S_RUN);
        squash     = commitValid & mispredict;
        fetch_fire = run & fetchValid & ~squash;
        repair     = run & squash;
        idx        = fetchPC ^ ghr_q;
    end

    // Saturating increment/decrement of the counter carried through the ROB.
    always_comb begin
        sat_val = commitState;
        if (commitTaken) begin
            if (commitState != {CTR_W{1'b1}}) begin
                sat_val = commitState + CTR_W'(1);
            end
        end else begin
            if (commitState != {CTR_W{1'b0}}) begin
                sat_val = commitState - CTR_W'(1);
            end
        end
    end

    // Write-first read: a same-cycle commit to the fetched entry is forwarded.
    always_comb begin
        bypass   = run & commitValid & (commitIndex == idx);
        rd_state = bypass ? sat_val : pht[idx];
    end

    // FSM next state and PHT write port selection (sweep vs. commit).
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        wr_en   = 1'b0;
        wr_idx  = commitIndex;
        wr_data = sat_val;
        case (state_q)
            S_INIT: begin
                wr_en   = 1'b1;
                wr_idx  = sweep_q;
                wr_data = INIT_STATE;
                sweep_d = sweep_q + IDX_W'(1);
                if (sweep_q == {IDX_W{1'b1}}) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                wr_en = commitValid;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // FSM state, sweep pointer and ready flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            sweep_q <= '0;
            ready   <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            ready   <= (state_d == S_RUN);
        end
    end

    // PHT storage; contents are established by the sweep, not by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pht[wr_idx] <= wr_data;
        end
    end

    // Global history: repair on mispredict, otherwise speculative shift on fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_q <= '0;
        end else if (repair) begin
            ghr_q <= {commitHistory[IDX_W-2:0], commitTaken};
        end else if (fetch_fire) begin
            ghr_q <= {ghr_q[IDX_W-2:0], rd_state[CTR_W-1]};
        end
    end

    // Registered prediction outputs; payload holds when no fetch fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            predictValid   <= 1'b0;
            predictTaken   <= 1'b0;
            predictIndex   <= '0;
            predictState   <= '0;
            predictHistory <= '0;
        end else begin
            predictValid <= fetch_fire;
            if (fetch_fire) begin
                predictTaken   <= rd_state[CTR_W-1];
                predictIndex   <= idx;
                predictState   <= rd_state;
                predictHistory <= ghr_q;
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed steps from the test plan
// plus randomized traffic against a behavioural table/history model.
module tb_gshare_predictor;

    localparam int IDX_W = 8;
    localparam int CTR_W = 2;
    localparam int DEPTH = 1 << IDX_W;
    localparam int CMAX  = (1 << CTR_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             fetchValid = 1'b0;
    logic [IDX_W-1:0] fetchPC = '0;
    logic             ready;
    logic             predictValid;
    logic             predictTaken;
    logic [IDX_W-1:0] predictIndex;
    logic [CTR_W-1:0] predictState;
    logic [IDX_W-1:0] predictHistory;
    logic             commitValid = 1'b0;
    logic [IDX_W-1:0] commitIndex = '0;
    logic [CTR_W-1:0] commitState = '0;
    logic [IDX_W-1:0] commitHistory = '0;
    logic             commitTaken = 1'b0;
    logic             mispredict = 1'b0;

    int tests = 0;
    int fails = 0;

    // behavioural model
    int m_pht [DEPTH];
    int m_ghr;
    int m_ready;
    int m_pv;
    int m_pt;
    int m_pi;
    int m_ps;
    int m_ph;

    logic [IDX_W-1:0] r_pc;
    logic [IDX_W-1:0] r_ci;

    gshare_predictor #(.IDX_W(IDX_W), .CTR_W(CTR_W)) dut (
        .clk(clk),
        .reset(reset),
        .fetchValid(fetchValid),
        .fetchPC(fetchPC),
        .ready(ready),
        .predictValid(predictValid),
        .predictTaken(predictTaken),
        .predictIndex(predictIndex),
        .predictState(predictState),
        .predictHistory(predictHistory),
        .commitValid(commitValid),
        .commitIndex(commitIndex),
        .commitState(commitState),
        .commitHistory(commitHistory),
        .commitTaken(commitTaken),
        .mispredict(mispredict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("ready", 32'(ready), 32'(m_ready));
        chk("predictValid", 32'(predictValid), 32'(m_pv));
        chk("predictTaken", 32'(predictTaken), 32'(m_pt));
        chk("predictIndex", 32'(predictIndex), 32'(m_pi));
        chk("predictState", 32'(predictState), 32'(m_ps));
        chk("predictHistory", 32'(predictHistory), 32'(m_ph));
    endtask

    task automatic model_reset();
        m_ghr = 0; m_ready = 0; m_pv = 0; m_pt = 0; m_pi = 0; m_ps = 0; m_ph = 0;
    endtask

    // One RUN cycle: drive inputs, advance the model, check after the edge.
    task automatic step(input logic fv, input logic [IDX_W-1:0] pc,
                        input logic cv, input logic [IDX_W-1:0] ci,
                        input logic [CTR_W-1:0] cs, input logic [IDX_W-1:0] ch,
                        input logic ct, input logic mp);
        int idx;
        int rd;
        int nv;
        fetchValid = fv; fetchPC = pc;
        commitValid = cv; commitIndex = ci; commitState = cs;
        commitHistory = ch; commitTaken = ct; mispredict = mp;
        if (m_ready != 0) begin
            idx = (int'(pc) ^ m_ghr) % DEPTH;
            if (cv) begin
                if (ct) nv = (int'(cs) == CMAX) ? CMAX : int'(cs) + 1;
                else    nv = (int'(cs) == 0) ? 0 : int'(cs) - 1;
                m_pht[int'(ci)] = nv;
            end
            rd = m_pht[idx];
            if (cv && mp) begin
                m_pv  = 0;
                m_ghr = ((int'(ch) * 2) + int'(ct)) % DEPTH;
            end else if (fv) begin
                m_pv  = 1;
                m_pt  = rd / (1 << (CTR_W - 1));
                m_pi  = idx;
                m_ps  = rd;
                m_ph  = m_ghr;
                m_ghr = ((m_ghr * 2) + m_pt) % DEPTH;
            end else begin
                m_pv = 0;
            end
        end else begin
            m_pv = 0;
        end
        @(posedge clk); #1;
        check_outputs();
    endtask

    // Sweep period with fetch and (would-be destructive) commits held active.
    task automatic run_init();
        for (int i = 0; i < DEPTH; i++) begin
            fetchValid = 1'b1; fetchPC = IDX_W'($urandom);
            commitValid = 1'b1; commitIndex = IDX_W'($urandom); commitState = '0;
            commitTaken = 1'b0; mispredict = 1'b0;
            @(posedge clk); #1;
            chk("init_ready", 32'(ready), (i == DEPTH - 1) ? 32'd1 : 32'd0);
            chk("init_predictValid", 32'(predictValid), 32'd0);
        end
        for (int i = 0; i < DEPTH; i++) m_pht[i] = 1 << (CTR_W - 1);
        m_ready = 1;
        m_pv = 0;
        fetchValid = 1'b0; commitValid = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;
        run_init();

        // first prediction after init
        step(1'b1, 8'h00, 1'b0, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0);
        chk("first_state", 32'(predictState), 32'h2);
        chk("first_taken", 32'(predictTaken), 32'h1);

        // saturation at both ends and a normal increment
        step(1'b0, 8'h00, 1'b1, 8'h05, 2'b11, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'(32'h05 ^ m_ghr), 1'b0, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0);
        chk("sat_high", 32'(predictState), 32'h3);
        step(1'b0, 8'h00, 1'b1, 8'h05, 2'b00, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'(32'h05 ^ m_ghr), 1'b0, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0);
        chk("sat_low", 32'(predictState), 32'h0);
        step(1'b0, 8'h00, 1'b1, 8'h05, 2'b01, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'(32'h05 ^ m_ghr), 1'b0, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0);
        chk("inc_01", 32'(predictState), 32'h2);

        // clear history via a repair, then two back-to-back fetches
        step(1'b0, 8'h00, 1'b1, 8'h7F, 2'b01, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h10, 1'b0, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0);
        chk("ghr_idx0", 32'(predictIndex), 32'h10);
        chk("ghr_hist0", 32'(predictHistory), 32'h00);
        step(1'b1, 8'h10, 1'b0, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0);
        chk("ghr_idx1", 32'(predictIndex), 32'h11);
        chk("ghr_hist1", 32'(predictHistory), 32'h01);

        // same-cycle commit/fetch collision
        step(1'b1, 8'(32'h3C ^ m_ghr), 1'b1, 8'h3C, 2'b10, 8'h00, 1'b0, 1'b0);
        chk("bypass_state", 32'(predictState), 32'h1);
        chk("bypass_taken", 32'(predictTaken), 32'h0);

        // mispredict squashes a concurrent fetch and repairs history
        step(1'b1, 8'h33, 1'b1, 8'h20, 2'b10, 8'hA5, 1'b0, 1'b1);
        chk("squash_valid", 32'(predictValid), 32'h0);
        step(1'b1, 8'h00, 1'b0, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0);
        chk("repair_idx", 32'(predictIndex), 32'h4A);
        chk("repair_hist", 32'(predictHistory), 32'h4A);

        // randomized traffic with frequent index collisions
        for (int k = 0; k < 2000; k++) begin
            r_pc = IDX_W'($urandom);
            r_ci = ($urandom_range(3) == 0) ? IDX_W'(32'(r_pc) ^ m_ghr) : IDX_W'($urandom);
            step($urandom_range(3) != 0, r_pc, 1'($urandom), r_ci, CTR_W'($urandom),
                 IDX_W'($urandom), 1'($urandom), $urandom_range(7) == 0);
        end

        // reset during RUN, then again mid-sweep
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            chk("sweep1_ready", 32'(ready), 32'd0);
        end
        reset = 1'b1;
        #1;
        check_outputs();
        @(posedge clk); #1;
        reset = 1'b0;
        run_init();

        // every entry must read the init value again
        for (int t = 0; t < DEPTH; t++) begin
            step(1'b1, 8'(t ^ m_ghr), 1'b0, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0);
            chk("sweep_entry", 32'(predictState), 32'h2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
